// File: rtl/alien_step_ctrl.sv
// Alien formation step controller: prescaled movement ticks, column/row tracking and step pulse.
// Optional feature macro: ALIEN_STEP_SPEEDUP_EN (shortens the tick period as the formation descends).
module alien_step_ctrl #(
    parameter int PRESCALE_MAX = 2500000,
    parameter int COL_MAX      = 10,
    parameter int ROW_MAX      = 7
) (
    input  logic       SC_COUNTER_CLOCK_50,
    input  logic       SC_COUNTER_RESET_InLow,
    input  logic [1:0] dir_code,
    input  logic       run_InLow,
    input  logic       clear_InLow,
    output logic       step_OutLow,
    output logic [3:0] col,
    output logic [2:0] row,
    output logic       landed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        STEP  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [21:0] PRESCALE_W = 22'(PRESCALE_MAX);
    localparam logic [3:0]  COL_LIM    = 4'(COL_MAX);
    localparam logic [2:0]  ROW_LIM    = 3'(ROW_MAX);

    state_t      state_q, state_d;
    logic [21:0] presc_q, presc_d;
    logic [3:0]  col_q, col_d;
    logic [2:0]  row_q, row_d;
    logic [21:0] term_m1;
    logic        tick;

`ifdef ALIEN_STEP_SPEEDUP_EN
    // Terminal value halves per row down to row 3, never below one cycle.
    logic [1:0]  shamt;
    logic [21:0] term;
    always_comb begin
        shamt = (row_q >= 3'd3) ? 2'd3 : row_q[1:0];
        term  = PRESCALE_W >> shamt;
        if (term == 22'd0) begin
            term = 22'd1;
        end
    end
    assign term_m1 = term - 22'd1;
`else
    assign term_m1 = PRESCALE_W - 22'd1;
`endif

    assign tick = (state_q == IDLE) && !run_InLow && (presc_q == term_m1);

    always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
        if (!SC_COUNTER_RESET_InLow) begin
            state_q <= IDLE;
            presc_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        col_d   = col_q;
        row_d   = row_q;
        if (!clear_InLow) begin
            state_d = IDLE;
            presc_d = '0;
            col_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!run_InLow) begin
                        if (tick) begin
                            presc_d = '0;
                            state_d = APPLY;
                        end else begin
                            presc_d = presc_q + 22'd1;
                        end
                    end
                end
                APPLY: begin
                    state_d = STEP;
                    case (dir_code)
                        2'b01:   if (col_q < COL_LIM) col_d = col_q + 4'd1;
                        2'b10:   if (col_q != 4'd0)   col_d = col_q - 4'd1;
                        2'b00:   if (row_q < ROW_LIM) row_d = row_q + 3'd1;
                        default: ;
                    endcase
                end
                STEP:    state_d = (row_q == ROW_LIM) ? HALT : IDLE;
                default: state_d = HALT;
            endcase
        end
    end

    // Pulse is decoded from state so reset removes it immediately.
    assign step_OutLow = (state_q != STEP);
    assign col         = col_q;
    assign row         = row_q;
    assign landed      = (row_q == ROW_LIM);

endmodule
